// File: rtl/vai_c1tx_arbiter_if.sv
// Request/issue bundle between the sub-AFU Tx auditors and the shared c1 Tx stage.
// master drives the per-requester packets; slave is the arbiter.
interface vai_c1tx_arbiter_if #(
  parameter int NUM_REQ = 8,
  parameter int PKT_W   = 64
);
  localparam int VW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*PKT_W-1:0] req_pkt;
  logic [NUM_REQ-1:0]       req_mask;
  logic [NUM_REQ-1:0]       req_almfull;
  logic                     tx_almfull;
  logic                     out_valid;
  logic [PKT_W-1:0]         out_pkt;
  logic [VW-1:0]            out_vmid;
  logic                     out_last;
  logic [NUM_REQ-1:0]       overflow_err;

  modport master (
    output req_valid, req_last, req_pkt, req_mask, tx_almfull,
    input  req_almfull, out_valid, out_pkt, out_vmid, out_last, overflow_err
  );

  modport slave (
    input  req_valid, req_last, req_pkt, req_mask, tx_almfull,
    output req_almfull, out_valid, out_pkt, out_vmid, out_last, overflow_err
  );
endinterface

// File: rtl/vai_c1tx_arbiter.sv
// Round-robin c1 Tx arbiter with per-requester FIFOs; bursts are never interleaved.
// Write-to-out_valid latency is 2 cycles; tx_almfull stalls all pops and keeps any burst lock.
module vai_c1tx_arbiter #(
  parameter int NUM_REQ       = 8,
  parameter int PKT_W         = 64,
  parameter int DEPTH         = 4,
  parameter int ALMFULL_SLACK = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  vai_c1tx_arbiter_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int VW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - ALMFULL_SLACK);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [VW-1:0]   owner, owner_nxt, rr_ptr, rr_nxt;

  // Each entry is {pkt, last}
  logic [PKT_W:0]  mem    [NUM_REQ][DEPTH];
  logic [AW-1:0]   wr_ptr [NUM_REQ];
  logic [AW-1:0]   rd_ptr [NUM_REQ];
  logic [CW-1:0]   count  [NUM_REQ];

  logic [NUM_REQ-1:0] eligible, push, accept, pop_sel;
  logic               pop_vld;
  logic [VW-1:0]      pop_idx, cand;
  logic [PKT_W:0]     head;

  always_comb begin
    eligible = '0;
    push     = '0;
    accept   = '0;
    pop_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = (count[i] != '0) & ~bus.req_mask[i];
      push[i]     = bus.req_valid[i] & ~bus.req_mask[i];
      pop_sel[i]  = pop_vld && (pop_idx == VW'(i));
      // A pop in the same cycle frees the slot, so a full FIFO still accepts
      accept[i]   = push[i] & ((count[i] != FULL_CNT) | pop_sel[i]);
    end
  end

  assign head = mem[pop_idx][rd_ptr[pop_idx]];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ARB;
      owner  <= '0;
      rr_ptr <= VW'(NUM_REQ - 1);
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    case (state)
      ARB: begin
        if (pop_vld) begin
          if (head[0]) begin
            rr_nxt = pop_idx;
          end else begin
            state_nxt = LOCKED;
            owner_nxt = pop_idx;
          end
        end
      end
      LOCKED: begin
        // Masking the owner aborts its burst without emitting a last beat
        if (bus.req_mask[owner] || (pop_vld && head[0])) begin
          state_nxt = ARB;
          rr_nxt    = owner;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    pop_vld = 1'b0;
    pop_idx = '0;
    cand    = '0;
    if (!bus.tx_almfull) begin
      if (state == LOCKED) begin
        pop_vld = eligible[owner];
        pop_idx = owner;
      end else begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = VW'((int'(rr_ptr) + k) % NUM_REQ);
          if (!pop_vld && eligible[cand]) begin
            pop_vld = 1'b1;
            pop_idx = cand;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) mem[i][wr_ptr[i]] <= {bus.req_pkt[i*PKT_W +: PKT_W], bus.req_last[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      bus.req_almfull  <= '0;
      bus.overflow_err <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_mask[i]) begin
          count[i]  <= '0;
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
        end else begin
          if (accept[i])  wr_ptr[i] <= wr_ptr[i] + AW'(1);
          if (pop_sel[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
          count[i] <= count[i] + CW'(accept[i]) - CW'(pop_sel[i]);
          if (push[i] & ~accept[i]) bus.overflow_err[i] <= 1'b1;
        end
        bus.req_almfull[i] <= (count[i] >= AF_CNT) | bus.req_mask[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_pkt   <= '0;
      bus.out_vmid  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      bus.out_valid <= pop_vld;
      if (pop_vld) begin
        bus.out_pkt  <= head[PKT_W:1];
        bus.out_last <= head[0];
        bus.out_vmid <= pop_idx;
      end
    end
  end
endmodule

// File: tb/tb_vai_c1tx_arbiter.sv
// Directed bench for vai_c1tx_arbiter: stimulus queues expected issues, a monitor checks them.
module tb_vai_c1tx_arbiter;
  localparam int N = 8;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vai_c1tx_arbiter_if #(.NUM_REQ(N), .PKT_W(W)) bus();

  vai_c1tx_arbiter #(.NUM_REQ(N), .PKT_W(W), .DEPTH(4), .ALMFULL_SLACK(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [67:0] exp_q[$];
  logic [67:0] exp_e;
  int bad;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got vmid=%0d last=%b pkt=%h, expected no output",
                 bus.out_vmid, bus.out_last, bus.out_pkt);
      end else begin
        exp_e = exp_q.pop_front();
        check("sb_out", {bus.out_vmid, bus.out_last, bus.out_pkt}, exp_e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_last  = '0;
  endtask

  task automatic drive(input int i, input logic last, input logic [63:0] pkt);
    bus.req_valid[i]     = 1'b1;
    bus.req_last[i]      = last;
    bus.req_pkt[i*W +: W] = pkt;
  endtask

  task automatic expect_pkt(input int v, input logic last, input logic [63:0] pkt);
    exp_q.push_back({3'(v), last, pkt});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    repeat (4) step();
    check(name, 68'(exp_q.size()), 68'd0);
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_last   = '0;
    bus.req_pkt    = '0;
    bus.req_mask   = '0;
    bus.tx_almfull = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_vmid", bus.out_vmid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_almfull", bus.req_almfull, 0);
    check("rst_overflow", bus.overflow_err, 0);
    reset = 1'b0;
    step();

    // 1: all requesters single beat in one cycle -> vmid 0..7 back to back
    for (int i = 0; i < N; i++) begin
      drive(i, 1'b1, 64'h100 + 64'(i));
      expect_pkt(i, 1'b1, 64'h100 + 64'(i));
    end
    step();
    idle();
    step();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t1_continuous", bus.out_valid, 1);
      step();
    end
    @(negedge clk);
    check("t1_end_gap", bus.out_valid, 0);
    check("t1_no_overflow", bus.overflow_err, 0);
    drain("t1_drain");

    // 2: req2 4-beat burst, req3 single beat one cycle later
    expect_pkt(2, 1'b0, 64'h200);
    expect_pkt(2, 1'b0, 64'h201);
    expect_pkt(2, 1'b0, 64'h202);
    expect_pkt(2, 1'b1, 64'h203);
    expect_pkt(3, 1'b1, 64'h300);
    idle(); drive(2, 1'b0, 64'h200); step();
    idle(); drive(2, 1'b0, 64'h201); drive(3, 1'b1, 64'h300); step();
    idle(); drive(2, 1'b0, 64'h202); step();
    idle(); drive(2, 1'b1, 64'h203); step();
    idle();
    drain("t2_drain");

    // 3: downstream backpressure for 10 cycles
    for (int k = 0; k < 3; k++) expect_pkt(1, 1'b1, 64'h110 + 64'(k));
    bus.tx_almfull = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      idle();
      if (k < 3) drive(1, 1'b1, 64'h110 + 64'(k));
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad++;
      if (k == 5) check("t3_almfull", bus.req_almfull, 8'h02);
      step();
    end
    check("t3_blocked_cycles", bad, 0);
    bus.tx_almfull = 1'b0;
    @(negedge clk);
    check("t3_release_latency", bus.out_valid, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_consecutive", bus.out_valid, 1);
      step();
    end
    @(negedge clk);
    check("t3_after", bus.out_valid, 0);
    drain("t3_drain");

    // 4: overflow on a 4-deep FIFO
    bus.tx_almfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle();
      drive(5, 1'b1, 64'h500 + 64'(k));
      if (k < 4) expect_pkt(5, 1'b1, 64'h500 + 64'(k));
      step();
    end
    idle();
    step();
    @(negedge clk);
    check("t4_overflow", bus.overflow_err, 8'h20);
    check("t4_almfull5", bus.req_almfull[5], 1);
    bus.tx_almfull = 1'b0;
    drain("t4_drain");
    check("t4_sticky", bus.overflow_err, 8'h20);

    // 4b: write into a full FIFO in the same cycle as its pop is not an overflow
    bus.tx_almfull = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle();
      drive(7, 1'b1, 64'h700 + 64'(k));
      expect_pkt(7, 1'b1, 64'h700 + 64'(k));
      step();
    end
    idle();
    drive(7, 1'b1, 64'h704);
    expect_pkt(7, 1'b1, 64'h704);
    bus.tx_almfull = 1'b0;
    step();
    idle();
    drain("t4b_drain");
    check("t4b_no_overflow", bus.overflow_err, 8'h20);

    // 5: mask req4 mid-burst; pending req6 goes next
    expect_pkt(4, 1'b0, 64'h400);
    expect_pkt(4, 1'b0, 64'h401);
    expect_pkt(6, 1'b1, 64'h600);
    idle(); drive(4, 1'b0, 64'h400); step();
    idle(); drive(4, 1'b0, 64'h401); drive(6, 1'b1, 64'h600); step();
    idle(); drive(4, 1'b0, 64'h402); step();
    idle(); drive(4, 1'b1, 64'h403); bus.req_mask[4] = 1'b1; step();
    idle(); bus.req_mask = '0;
    @(negedge clk);
    check("t5_bubble", bus.out_valid, 0);
    check("t5_mask_almfull", bus.req_almfull[4], 1);
    step();
    @(negedge clk);
    check("t5_req6_issued", {bus.out_valid, bus.out_vmid}, {1'b1, 3'd6});
    drain("t5_drain");
    check("t5_overflow_kept", bus.overflow_err, 8'h20);

    // 6: reset during a locked burst
    expect_pkt(2, 1'b0, 64'h2a0);
    idle(); drive(2, 1'b0, 64'h2a0); step();
    idle(); drive(2, 1'b0, 64'h2a1); step();
    idle(); reset = 1'b1; step();
    @(negedge clk);
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_overflow", bus.overflow_err, 0);
    check("t6_rst_almfull", bus.req_almfull, 0);
    step();
    reset = 1'b0;
    expect_pkt(0, 1'b1, 64'h0b0);
    expect_pkt(5, 1'b1, 64'h5b0);
    drive(5, 1'b1, 64'h5b0);
    drive(0, 1'b1, 64'h0b0);
    step();
    idle();
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vai_c1tx_arbiter.md
Name: vai_c1tx_arbiter

Overview:
Round-robin arbiter that shares the single CCI-P c1 Tx (write-request) channel between NUM_REQ sub-AFUs. It sits between the per-sub-AFU Tx auditors and the manager's Tx stage. Each requester gets its own small input FIFO, and its own almost-full is derived from that FIFO's fill level. Multi-beat write bursts are never interleaved, and every issued packet is tagged with its vmid.

Parameters:
NUM_REQ, 8, number of requesters (sub-AFUs); must be 2..16.
PKT_W, 64, width of one flattened c1 Tx packet (header + data); widened to the c1 Tx struct width at instantiation.
DEPTH, 4, per-requester FIFO depth; must be a power of two, >= 4.
ALMFULL_SLACK, 2, number of free entries at or below which req_almfull asserts.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester packet valid
req_last  in  NUM_REQ  packet is the final beat of its burst; single-beat writes assert it
req_pkt  in  NUM_REQ*PKT_W  packets; requester i occupies bits [i*PKT_W +: PKT_W]
req_mask  in  NUM_REQ  requester held in reset/disabled
req_almfull  out  NUM_REQ  per-requester backpressure
tx_almfull  in  1  downstream c1TxAlmFull
out_valid  out  1  packet issued
out_pkt  out  PKT_W  issued packet
out_vmid  out  $clog2(NUM_REQ)  index of the requester that issued
out_last  out  1  last beat of the issued burst
overflow_err  out  NUM_REQ  sticky: a write into a full FIFO was dropped

Behaviour:
- Reset: all FIFO counts 0; all outputs 0; state ARB; rr_ptr = NUM_REQ-1 so requester 0 wins first.
- FIFO write:
  - req_valid[i] & ~req_mask[i] writes {pkt, last} into FIFO i.
  - If FIFO i is full, the packet is dropped, count is unchanged, and overflow_err[i] sets. It clears only on reset.
  - A write and a pop on the same FIFO in the same cycle leave the count unchanged. On a full FIFO this is legal and not an overflow.
- req_almfull[i]: registered, equal to (count_i >= DEPTH-ALMFULL_SLACK) | req_mask[i]. It is one cycle late, which the slack covers.
- req_mask[i] high: FIFO i flushes to count 0 next cycle and input is ignored. If the state is LOCKED with owner i, it returns to ARB with rr_ptr = i and no out_last is emitted (burst aborted). overflow_err[i] is unaffected.
- Issue condition, evaluated each cycle on registered FIFO state: tx_almfull==0 and an eligible head exists. At most one pop per cycle.
- State ARB:
  - Winner = first i scanning rr_ptr+1 .. rr_ptr+NUM_REQ (mod NUM_REQ) with count_i != 0 & ~req_mask[i].
  - Pop the winner's head. If the head's last=1: stay in ARB, rr_ptr = winner. Otherwise go to LOCKED with owner = winner.
- State LOCKED(owner):
  - Only the owner is eligible. If the owner's FIFO is empty, the cycle is a bubble and other requesters still wait.
  - On popping last=1: go to ARB, rr_ptr = owner.
- Output register: on a pop at cycle t, out_valid=1 with out_pkt, out_vmid, out_last at t+1. On cycles with no pop, out_valid=0; out_pkt/out_vmid/out_last hold their values and are don't-care.
- Latency: a write at cycle t makes FIFO i nonempty at t+1, pops at t+1 at the earliest, and appears on out_valid at t+2.
- tx_almfull: high blocks all pops, including mid-burst. The burst lock is retained while blocked.
- Counts: width $clog2(DEPTH)+1. Read/write pointers are $clog2(DEPTH) bits and wrap naturally.

Test Plan:
1. Single-beat fairness: all 8 requesters write one last=1 packet in cycle 0 -> out_vmid 0,1,...,7 on cycles 2..9, out_valid continuous, no overflow_err.
2. Burst lock: req 2 writes a 4-beat burst (last on beat 4) while req 3 writes a single beat one cycle later -> four consecutive vmid=2 outputs, then vmid=3; no interleave.
3. Backpressure: tx_almfull held high for 10 cycles while req 1 writes 3 packets -> out_valid stays 0 and req_almfull[1]=1 once count >= 2; after release, 3 packets out on consecutive cycles.
4. Overflow: tx_almfull high, req 5 writes 5 packets into DEPTH=4 -> 5th dropped, overflow_err[5]=1 thereafter, and exactly 4 packets out after release.
5. Mask mid-burst: req 4 issues 2 of 4 beats, then req_mask[4] is pulsed -> FIFO 4 flushed, arbiter in ARB, and a pending req 6 single beat issues within 2 cycles.
6. Reset mid-burst: assert reset during a LOCKED burst -> next cycle out_valid=0, overflow_err=0, and requester 0 wins first after release.
